// File: rtl/decode_pkg.sv
// decode_pkg: shared types for the RV32I decode stage.
//   - RV32I opcode constants
//   - trap-cause, writeback-source and ALU input-1 select enums
//   - bundle_t: the decoded instruction bundle held in the stage output register
//   - byte-enable / misalignment helpers for loads and stores
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    CAUSE_FETCH_MISALIGN = 4'd0,
    CAUSE_ILLEGAL        = 4'd2,
    CAUSE_BREAKPOINT     = 4'd3,
    CAUSE_LOAD_MISALIGN  = 4'd4,
    CAUSE_STORE_MISALIGN = 4'd6,
    CAUSE_ECALL          = 4'd11
  } trap_cause_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_src_e;

  typedef enum logic [1:0] {
    IN1_RS1  = 2'd0,
    IN1_PC   = 2'd1,
    IN1_ZERO = 2'd2
  } alu_in1_e;

  typedef struct packed {
    logic [4:0]  reg_in_sel;
    logic        reg_in_en;
    wb_src_e     reg_in_source;
    logic [2:0]  alu_op;
    logic        alu_op_qual;
    alu_in1_e    alu_in1_sel;
    logic        alu_in2_sel;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        d_re;
    logic        d_we;
    logic [3:0]  d_be;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] redirect_pc;
    logic        trap;
    trap_cause_e trap_cause;
    logic        mdu;
  } bundle_t;

  // size is funct3[1:0]: 0 byte, 1 half, 2 word
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] ofs);
    logic [3:0] base;
    case (size)
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << ofs;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ofs);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = ofs[0];
      default: bad = (ofs != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-to-decode handshake.
//   in_valid_i / instr_i / pc_i : driven by fetch (master)
//   in_ready_o                  : driven by the decode stage (slave)
// Signal suffixes are written from the decode stage's point of view.
interface decode_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;

  modport master (output in_valid_i, instr_i, pc_i, input in_ready_o);
  modport slave  (input in_valid_i, instr_i, pc_i, output in_ready_o);
endinterface

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I decoder.
//   instr_i, pc_i           : instruction and its byte PC
//   rs1_data_i, rs2_data_i  : register-file read data for this instruction
//   bundle_o                : fully decoded bundle, including trap status
//   redirect_o              : branch taken / jump with an aligned target
// Optional macro DECODE_RV32M_EN enables MUL..REMU decode (bundle_o.mdu).
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output bundle_t     bundle_o,
  output logic        redirect_o
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [31:0] ld_addr, st_addr;
  logic        br_take;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign i_imm = {{20{instr_i[31]}}, instr_i[31:20]};
  assign s_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign b_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign u_imm = {instr_i[31:12], 12'b0};
  assign j_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  assign ld_addr = rs1_data_i + i_imm;
  assign st_addr = rs1_data_i + s_imm;

  always_comb begin
    case (funct3)
      3'b000:  br_take = (rs1_data_i == rs2_data_i);
      3'b001:  br_take = (rs1_data_i != rs2_data_i);
      3'b100:  br_take = ($signed(rs1_data_i) <  $signed(rs2_data_i));
      3'b101:  br_take = ($signed(rs1_data_i) >= $signed(rs2_data_i));
      3'b110:  br_take = (rs1_data_i <  rs2_data_i);
      3'b111:  br_take = (rs1_data_i >= rs2_data_i);
      default: br_take = 1'b0;
    endcase
  end

  logic        wr, take, trap;
  logic [31:0] target;
  trap_cause_e cause;
  bundle_t     b;

  always_comb begin
    b               = '0;
    b.reg_in_sel    = rd;
    b.rs1_data      = rs1_data_i;
    b.rs2_data      = rs2_data_i;
    b.reg_in_source = WB_ALU;
    b.alu_in1_sel   = IN1_RS1;
    wr              = 1'b0;
    take            = 1'b0;
    target          = 32'h0;
    trap            = 1'b0;
    cause           = CAUSE_ILLEGAL;

    // alu_op stays 000 (add) for everything except ALU ops and branches
    case (opcode)
      OP_LUI: begin
        wr = 1'b1; b.alu_in1_sel = IN1_ZERO; b.alu_in2_sel = 1'b1; b.imm = u_imm;
      end
      OP_AUIPC: begin
        wr = 1'b1; b.alu_in1_sel = IN1_PC; b.alu_in2_sel = 1'b1; b.imm = u_imm;
      end
      OP_JAL: begin
        wr = 1'b1; b.reg_in_source = WB_PC4; b.alu_in1_sel = IN1_PC; b.alu_in2_sel = 1'b1;
        b.imm = j_imm; take = 1'b1; target = pc_i + j_imm;
      end
      OP_JALR: begin
        wr = 1'b1; b.reg_in_source = WB_PC4; b.alu_in2_sel = 1'b1; b.imm = i_imm;
        take = 1'b1; target = ld_addr & ~32'd1;
        if (funct3 != 3'b000) trap = 1'b1;
      end
      OP_BRANCH: begin
        b.alu_op = funct3; b.imm = b_imm; take = br_take; target = pc_i + b_imm;
        if (funct3[2:1] == 2'b01) trap = 1'b1;
      end
      OP_LOAD: begin
        wr = 1'b1; b.reg_in_source = WB_MEM; b.alu_in2_sel = 1'b1; b.imm = i_imm;
        b.d_re = 1'b1; b.d_unsigned = funct3[2]; b.d_addr = ld_addr;
        b.d_be = byte_en(funct3[1:0], ld_addr[1:0]);
        if (misaligned(funct3[1:0], ld_addr[1:0])) begin
          trap = 1'b1; cause = CAUSE_LOAD_MISALIGN;
        end
        // illegal widths override a misalignment cause
        if (funct3 == 3'b011 || funct3[2:1] == 2'b11) begin
          trap = 1'b1; cause = CAUSE_ILLEGAL;
        end
      end
      OP_STORE: begin
        b.alu_in2_sel = 1'b1; b.imm = s_imm; b.d_we = 1'b1; b.d_addr = st_addr;
        b.d_be = byte_en(funct3[1:0], st_addr[1:0]);
        if (misaligned(funct3[1:0], st_addr[1:0])) begin
          trap = 1'b1; cause = CAUSE_STORE_MISALIGN;
        end
        if (funct3[2] || funct3[1:0] == 2'b11) begin
          trap = 1'b1; cause = CAUSE_ILLEGAL;
        end
      end
      OP_IMM: begin
        wr = 1'b1; b.alu_op = funct3; b.alu_in2_sel = 1'b1; b.imm = i_imm;
        // only shifts carry a funct7; elsewhere bit 30 is immediate data
        if (funct3 == 3'b001 && funct7 != 7'b0000000) trap = 1'b1;
        if (funct3 == 3'b101) begin
          b.alu_op_qual = instr_i[30];
          if (funct7 != 7'b0000000 && funct7 != 7'b0100000) trap = 1'b1;
        end
      end
      OP_OP: begin
        wr = 1'b1; b.alu_op = funct3; b.alu_op_qual = instr_i[30];
        case (funct7)
          7'b0000000: ;
          7'b0100000: if (funct3 != 3'b000 && funct3 != 3'b101) trap = 1'b1;
`ifdef DECODE_RV32M_EN
          7'b0000001: begin b.mdu = 1'b1; b.alu_op_qual = 1'b1; end
`endif
          default:    trap = 1'b1;
        endcase
      end
      OP_FENCE: begin
        if (funct3 != 3'b000) trap = 1'b1;
      end
      OP_SYSTEM: begin
        trap = 1'b1;
        if (instr_i == INSTR_ECALL)       cause = CAUSE_ECALL;
        else if (instr_i == INSTR_EBREAK) cause = CAUSE_BREAKPOINT;
      end
      default: trap = 1'b1;
    endcase

    // a taken control transfer to a non-word-aligned target traps instead of redirecting
    if (!trap && take && target[1]) begin
      trap = 1'b1; cause = CAUSE_FETCH_MISALIGN;
    end

    b.redirect_pc = target;
    b.reg_in_en   = wr && (rd != 5'd0) && !trap;
    if (trap) begin
      b.d_re = 1'b0;
      b.d_we = 1'b0;
    end
    b.trap       = trap;
    b.trap_cause = cause;
  end

  assign bundle_o   = b;
  assign redirect_o = take && !trap;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between fetch and execute.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   fetch_if (slave)       : in_valid_i / in_ready_o / instr_i / pc_i
//   reg_out*_sel_o / _i    : combinational register-file read port
//   flush_i                : drop held bundle and clear the wrong-path counter
//   out_valid_o/out_ready_i: output handshake; the remaining *_o are the held bundle
//   redirect_o/_pc_o       : one-cycle redirect pulse when the bundle first appears
//   mdu_o                  : M-extension op (only with macro DECODE_RV32M_EN)
// FETCH_LAT wrong-path slots are swallowed after every redirect.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned FETCH_LAT = 1,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  decode_if.slave     fetch_if,
  output logic [4:0]  reg_out1_sel_o,
  output logic [4:0]  reg_out2_sel_o,
  input  logic [31:0] reg_out1_i,
  input  logic [31:0] reg_out2_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [4:0]  reg_in_sel_o,
  output logic        reg_in_en_o,
  output logic [1:0]  reg_in_source_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_op_qual_o,
  output logic [1:0]  alu_in1_sel_o,
  output logic        alu_in2_sel_o,
  output logic [31:0] imm_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic        d_re_o,
  output logic        d_we_o,
  output logic [3:0]  d_be_o,
  output logic        d_unsigned_o,
  output logic [31:0] d_addr_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        trap_o,
  output logic [3:0]  trap_cause_o,
  output logic        mdu_o
);

  localparam logic [2:0] KILL_LOAD = 3'(FETCH_LAT);

  // RESET_PC belongs to fetch; it is only checked here for word alignment.
  if (RESET_PC[1:0] != 2'b00 || FETCH_LAT < 1 || FETCH_LAT > 7) begin : g_bad_config
  end

  bundle_t    dec_bundle, bundle_q, bundle_d;
  logic       dec_redirect;
  logic       out_valid_q, out_valid_d;
  logic       redirect_q, redirect_d;
  logic [2:0] kill_cnt_q, kill_cnt_d;
  logic       accept;

  assign fetch_if.in_ready_o = !out_valid_q || out_ready_i;
  assign accept              = fetch_if.in_valid_i && fetch_if.in_ready_o;
  assign reg_out1_sel_o      = fetch_if.instr_i[19:15];
  assign reg_out2_sel_o      = fetch_if.instr_i[24:20];

  decode_comb u_decode_comb (
    .instr_i    (fetch_if.instr_i),
    .pc_i       (fetch_if.pc_i),
    .rs1_data_i (reg_out1_i),
    .rs2_data_i (reg_out2_i),
    .bundle_o   (dec_bundle),
    .redirect_o (dec_redirect)
  );

  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    redirect_d  = 1'b0;       // pulse: only set in the cycle the bundle is captured
    kill_cnt_d  = kill_cnt_q;
    if (flush_i) begin
      // an offer in this cycle is still consumed by the handshake, then dropped
      out_valid_d = 1'b0;
      kill_cnt_d  = 3'd0;
    end else if (accept) begin
      if (kill_cnt_q != 3'd0) begin
        kill_cnt_d  = kill_cnt_q - 3'd1;
        out_valid_d = 1'b0;
      end else begin
        bundle_d    = dec_bundle;
        out_valid_d = 1'b1;
        redirect_d  = dec_redirect;
        if (dec_redirect) kill_cnt_d = KILL_LOAD;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      redirect_q  <= 1'b0;
      kill_cnt_q  <= 3'd0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      redirect_q  <= redirect_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign redirect_o      = redirect_q;
  assign reg_in_sel_o    = bundle_q.reg_in_sel;
  assign reg_in_en_o     = bundle_q.reg_in_en;
  assign reg_in_source_o = bundle_q.reg_in_source;
  assign alu_op_o        = bundle_q.alu_op;
  assign alu_op_qual_o   = bundle_q.alu_op_qual;
  assign alu_in1_sel_o   = bundle_q.alu_in1_sel;
  assign alu_in2_sel_o   = bundle_q.alu_in2_sel;
  assign imm_o           = bundle_q.imm;
  assign rs1_data_o      = bundle_q.rs1_data;
  assign rs2_data_o      = bundle_q.rs2_data;
  assign d_re_o          = bundle_q.d_re;
  assign d_we_o          = bundle_q.d_we;
  assign d_be_o          = bundle_q.d_be;
  assign d_unsigned_o    = bundle_q.d_unsigned;
  assign d_addr_o        = bundle_q.d_addr;
  assign redirect_pc_o   = bundle_q.redirect_pc;
  assign trap_o          = bundle_q.trap;
  assign trap_cause_o    = bundle_q.trap_cause;
  assign mdu_o           = bundle_q.mdu;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage (FETCH_LAT = 2).
// Inputs change on the falling edge; outputs are checked on the next falling edge.
module tb_decode_stage;

  localparam logic [31:0] I_NOP    = 32'h0000_0013;
  localparam logic [31:0] I_ADDI   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD    = 32'h0010_8133; // add  x2,x1,x1
  localparam logic [31:0] I_BEQ    = 32'h0073_8863; // beq  x7,x7,+16
  localparam logic [31:0] I_BNE    = 32'h0073_9863; // bne  x7,x7,+16
  localparam logic [31:0] I_JAL    = 32'h0080_00EF; // jal  x1,+8
  localparam logic [31:0] I_JALR   = 32'h0004_00E7; // jalr x1,0(x8)
  localparam logic [31:0] I_LH_OK  = 32'h0022_9303; // lh   x6,2(x5)
  localparam logic [31:0] I_LH_BAD = 32'h0012_9303; // lh   x6,1(x5)
  localparam logic [31:0] I_SW_BAD = 32'h0072_A123; // sw   x7,2(x5)
  localparam logic [31:0] I_SB     = 32'h0072_81A3; // sb   x7,3(x5)
  localparam logic [31:0] I_LUI    = 32'h1234_5237; // lui  x4,0x12345
  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_BAD    = 32'hFFFF_FFFF;
  localparam logic [31:0] I_MUL    = 32'h0220_81B3; // mul  x3,x1,x2

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  decode_if fetch_if();

  logic [4:0]  sel1, sel2;
  logic [31:0] rd1, rd2;
  logic        flush, out_ready, out_valid;
  logic [4:0]  reg_in_sel;
  logic        reg_in_en;
  logic [1:0]  reg_in_source;
  logic [2:0]  alu_op;
  logic        alu_op_qual;
  logic [1:0]  alu_in1_sel;
  logic        alu_in2_sel;
  logic [31:0] imm, rs1_data, rs2_data, d_addr, redirect_pc;
  logic        d_re, d_we, d_unsigned, redirect, trap, mdu;
  logic [3:0]  d_be, trap_cause;

  logic [31:0] rf [32];
  assign rd1 = rf[sel1];
  assign rd2 = rf[sel2];

  int n_checks = 0;
  int n_errors = 0;

  decode_stage #(.FETCH_LAT(2), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_if(fetch_if),
    .reg_out1_sel_o(sel1), .reg_out2_sel_o(sel2), .reg_out1_i(rd1), .reg_out2_i(rd2),
    .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .reg_in_sel_o(reg_in_sel), .reg_in_en_o(reg_in_en), .reg_in_source_o(reg_in_source),
    .alu_op_o(alu_op), .alu_op_qual_o(alu_op_qual), .alu_in1_sel_o(alu_in1_sel),
    .alu_in2_sel_o(alu_in2_sel), .imm_o(imm), .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
    .d_re_o(d_re), .d_we_o(d_we), .d_be_o(d_be), .d_unsigned_o(d_unsigned), .d_addr_o(d_addr),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc), .trap_o(trap),
    .trap_cause_o(trap_cause), .mdu_o(mdu)
  );

  // Drive one cycle of fetch stimulus from a falling edge, return at the next one.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    fetch_if.in_valid_i = v;
    fetch_if.instr_i    = ins;
    fetch_if.pc_i       = pc;
    if (v) $display("txn pc=%h instr=%h in_ready=%0b flush=%0b out_ready=%0b",
                    pc, ins, fetch_if.in_ready_o, flush, out_ready);
    @(negedge clk);
  endtask

  task automatic test_reset();
    fetch_if.in_valid_i = 1'b0; fetch_if.instr_i = I_NOP; fetch_if.pc_i = 32'h0;
    flush = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (fetch_if.in_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", fetch_if.in_ready_o); end
    n_checks++; if ({redirect, trap, reg_in_en, d_re, d_we} !== 5'b0) begin n_errors++; $display("FAIL reset_enables: got %b want 00000", {redirect, trap, reg_in_en, d_re, d_we}); end
    n_checks++; if (imm !== 32'h0) begin n_errors++; $display("FAIL reset_imm: got %h want 0", imm); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    step(1'b1, I_ADDI, 32'h0);
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid1: got %b want 1", out_valid); end
    n_checks++; if (imm !== 32'd5) begin n_errors++; $display("FAIL b2b_imm1: got %h want 5", imm); end
    n_checks++; if (alu_in2_sel !== 1'b1) begin n_errors++; $display("FAIL b2b_in2_1: got %b want 1", alu_in2_sel); end
    n_checks++; if ({reg_in_en, reg_in_sel} !== {1'b1, 5'd1}) begin n_errors++; $display("FAIL b2b_rd1: got %b want 100001", {reg_in_en, reg_in_sel}); end
    n_checks++; if (fetch_if.in_ready_o !== 1'b1) begin n_errors++; $display("FAIL b2b_ready: got %b want 1", fetch_if.in_ready_o); end
    step(1'b1, I_ADD, 32'h4);
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid2: got %b want 1", out_valid); end
    n_checks++; if (alu_in2_sel !== 1'b0) begin n_errors++; $display("FAIL b2b_in2_2: got %b want 0", alu_in2_sel); end
    n_checks++; if (reg_in_sel !== 5'd2) begin n_errors++; $display("FAIL b2b_rd2: got %0d want 2", reg_in_sel); end
    n_checks++; if (rs1_data !== 32'h11) begin n_errors++; $display("FAIL b2b_rs1data: got %h want 11", rs1_data); end
    n_checks++; if ({sel1, sel2} !== {5'd1, 5'd1}) begin n_errors++; $display("FAIL b2b_sel: got %h want 21", {sel1, sel2}); end
    step(1'b0, I_NOP, 32'h0);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_branch();
    step(1'b1, I_BEQ, 32'h100);
    n_checks++; if ({out_valid, redirect} !== 2'b11) begin n_errors++; $display("FAIL beq_redirect: got %b want 11", {out_valid, redirect}); end
    n_checks++; if (redirect_pc !== 32'h110) begin n_errors++; $display("FAIL beq_target: got %h want 110", redirect_pc); end
    n_checks++; if (reg_in_en !== 1'b0) begin n_errors++; $display("FAIL beq_wen: got %b want 0", reg_in_en); end
    step(1'b1, I_ADDI, 32'h104);
    n_checks++; if ({out_valid, redirect} !== 2'b00) begin n_errors++; $display("FAIL beq_kill1: got %b want 00", {out_valid, redirect}); end
    step(1'b1, I_ADD, 32'h108);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL beq_kill2: got %b want 0", out_valid); end
    step(1'b1, I_ADDI, 32'h110);
    n_checks++; if ({out_valid, redirect} !== 2'b10) begin n_errors++; $display("FAIL beq_resume: got %b want 10", {out_valid, redirect}); end
    step(1'b1, I_BNE, 32'h114);
    n_checks++; if ({out_valid, redirect} !== 2'b10) begin n_errors++; $display("FAIL bne_not_taken: got %b want 10", {out_valid, redirect}); end
    step(1'b1, I_ADDI, 32'h118);
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bne_no_kill: got %b want 1", out_valid); end
    step(1'b0, I_NOP, 32'h0);
  endtask

  task automatic test_jal_stalled();
    out_ready = 1'b0;
    step(1'b1, I_JAL, 32'h200);
    n_checks++; if ({out_valid, redirect} !== 2'b11) begin n_errors++; $display("FAIL jal_redirect: got %b want 11", {out_valid, redirect}); end
    n_checks++; if (redirect_pc !== 32'h208) begin n_errors++; $display("FAIL jal_target: got %h want 208", redirect_pc); end
    n_checks++; if ({reg_in_en, reg_in_source} !== 3'b110) begin n_errors++; $display("FAIL jal_wb: got %b want 110", {reg_in_en, reg_in_source}); end
    step(1'b0, I_NOP, 32'h0);
    n_checks++; if ({out_valid, redirect} !== 2'b10) begin n_errors++; $display("FAIL jal_single_pulse: got %b want 10", {out_valid, redirect}); end
    out_ready = 1'b1;
    step(1'b1, I_NOP, 32'h204);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL jal_kill1: got %b want 0", out_valid); end
    step(1'b1, I_NOP, 32'h208);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL jal_kill2: got %b want 0", out_valid); end
    step(1'b1, I_ADDI, 32'h208);
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL jal_resume: got %b want 1", out_valid); end
    step(1'b0, I_NOP, 32'h0);
  endtask

  task automatic test_load_store();
    step(1'b1, I_LH_OK, 32'h300);
    n_checks++; if ({d_re, d_be} !== 5'b11100) begin n_errors++; $display("FAIL lh_be: got %b want 11100", {d_re, d_be}); end
    n_checks++; if (d_addr !== 32'h1002) begin n_errors++; $display("FAIL lh_addr: got %h want 1002", d_addr); end
    n_checks++; if ({trap, reg_in_source} !== 3'b001) begin n_errors++; $display("FAIL lh_src: got %b want 001", {trap, reg_in_source}); end
    step(1'b1, I_LH_BAD, 32'h304);
    n_checks++; if ({trap, trap_cause} !== {1'b1, 4'd4}) begin n_errors++; $display("FAIL lh_misalign: got %b want 10100", {trap, trap_cause}); end
    n_checks++; if ({d_re, reg_in_en} !== 2'b00) begin n_errors++; $display("FAIL lh_misalign_en: got %b want 00", {d_re, reg_in_en}); end
    step(1'b1, I_SW_BAD, 32'h308);
    n_checks++; if ({trap, trap_cause, d_we} !== {1'b1, 4'd6, 1'b0}) begin n_errors++; $display("FAIL sw_misalign: got %b want 101100", {trap, trap_cause, d_we}); end
    step(1'b1, I_SB, 32'h30C);
    n_checks++; if ({trap, d_we, d_be} !== 6'b011000) begin n_errors++; $display("FAIL sb_be: got %b want 011000", {trap, d_we, d_be}); end
    n_checks++; if (rs2_data !== 32'h77) begin n_errors++; $display("FAIL sb_data: got %h want 77", rs2_data); end
    step(1'b0, I_NOP, 32'h0);
  endtask

  task automatic test_jalr_misaligned();
    step(1'b1, I_JALR, 32'h400);
    n_checks++; if ({out_valid, trap, trap_cause} !== {1'b1, 1'b1, 4'd0}) begin n_errors++; $display("FAIL jalr_trap: got %b want 110000", {out_valid, trap, trap_cause}); end
    n_checks++; if ({redirect, reg_in_en} !== 2'b00) begin n_errors++; $display("FAIL jalr_en: got %b want 00", {redirect, reg_in_en}); end
    step(1'b1, I_ADDI, 32'h404);
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL jalr_no_kill: got %b want 1", out_valid); end
    step(1'b0, I_NOP, 32'h0);
  endtask

  task automatic test_misc_decode();
    step(1'b1, I_LUI, 32'h500);
    n_checks++; if (imm !== 32'h1234_5000) begin n_errors++; $display("FAIL lui_imm: got %h want 12345000", imm); end
    n_checks++; if ({alu_in1_sel, alu_in2_sel, reg_in_sel} !== {2'd2, 1'b1, 5'd4}) begin n_errors++; $display("FAIL lui_sel: got %b want 10100100", {alu_in1_sel, alu_in2_sel, reg_in_sel}); end
    step(1'b1, I_ECALL, 32'h504);
    n_checks++; if ({trap, trap_cause} !== {1'b1, 4'd11}) begin n_errors++; $display("FAIL ecall: got %b want 11011", {trap, trap_cause}); end
    step(1'b1, I_BAD, 32'h508);
    n_checks++; if ({trap, trap_cause, reg_in_en} !== {1'b1, 4'd2, 1'b0}) begin n_errors++; $display("FAIL illegal: got %b want 100100", {trap, trap_cause, reg_in_en}); end
    step(1'b1, I_MUL, 32'h50C);
`ifdef DECODE_RV32M_EN
    n_checks++; if ({trap, mdu, alu_op_qual, reg_in_en} !== 4'b0111) begin n_errors++; $display("FAIL mul_mdu: got %b want 0111", {trap, mdu, alu_op_qual, reg_in_en}); end
`else
    n_checks++; if ({trap, trap_cause, mdu, reg_in_en} !== {1'b1, 4'd2, 1'b0, 1'b0}) begin n_errors++; $display("FAIL mul_illegal: got %b want 1001000", {trap, trap_cause, mdu, reg_in_en}); end
`endif
    step(1'b0, I_NOP, 32'h0);
  endtask

  task automatic test_stall_flush();
    out_ready = 1'b0;
    step(1'b1, I_ADDI, 32'h600);
    n_checks++; if ({out_valid, fetch_if.in_ready_o} !== 2'b10) begin n_errors++; $display("FAIL stall_c1: got %b want 10", {out_valid, fetch_if.in_ready_o}); end
    step(1'b1, I_ADD, 32'h604);
    n_checks++; if ({out_valid, fetch_if.in_ready_o, alu_in2_sel} !== 3'b101) begin n_errors++; $display("FAIL stall_c2: got %b want 101", {out_valid, fetch_if.in_ready_o, alu_in2_sel}); end
    n_checks++; if (imm !== 32'd5) begin n_errors++; $display("FAIL stall_hold_imm: got %h want 5", imm); end
    flush = 1'b1;
    step(1'b1, I_ADD, 32'h604);
    flush = 1'b0;
    n_checks++; if ({out_valid, fetch_if.in_ready_o} !== 2'b01) begin n_errors++; $display("FAIL stall_flush: got %b want 01", {out_valid, fetch_if.in_ready_o}); end
    out_ready = 1'b1;
    flush = 1'b1;
    step(1'b1, I_ADDI, 32'h608);
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_drop: got %b want 0", out_valid); end
    step(1'b1, I_BEQ, 32'h700);
    n_checks++; if (redirect !== 1'b1) begin n_errors++; $display("FAIL flush_beq: got %b want 1", redirect); end
    flush = 1'b1;
    step(1'b1, I_ADDI, 32'h704);
    flush = 1'b0;
    step(1'b1, I_ADD, 32'h110);
    n_checks++; if ({out_valid, reg_in_sel} !== {1'b1, 5'd2}) begin n_errors++; $display("FAIL flush_clears_kill: got %b want 100010", {out_valid, reg_in_sel}); end
    step(1'b0, I_NOP, 32'h0);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    step(1'b1, I_ADDI, 32'h800);
    fetch_if.in_valid_i = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL areset_pre: got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({out_valid, imm} !== {1'b0, 32'h0}) begin n_errors++; $display("FAIL areset_discard: got %b/%h want 0/0", out_valid, imm); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (fetch_if.in_ready_o !== 1'b1) begin n_errors++; $display("FAIL areset_ready: got %b want 1", fetch_if.in_ready_o); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'h11; rf[2] = 32'h22; rf[5] = 32'h1000; rf[7] = 32'h77; rf[8] = 32'h203;
    test_reset();
    test_back_to_back();
    test_branch();
    test_jal_stalled();
    test_load_store();
    test_jalr_misaligned();
    test_misc_decode();
    test_stall_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
